// File: rtl/uart_mult_ctrl_if.sv
// UART/multiplier controller bus bundle.
// Groups the receive strobe/data, the transmitter handshake, the multiplier
// handshake and the status outputs of uart_mult_ctrl.
//   master : the controller side (drives tx_start/data, mult operands/start,
//            busy, err_pulse)
//   slave  : the environment side (UART receiver/transmitter, multiplier)
interface uart_mult_ctrl_if;
    logic        uart_rx_valid;
    logic [7:0]  uart_received_data;
    logic        uart_tx_ready;
    logic        uart_tx_start;
    logic [7:0]  uart_transmit_data;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic        mult_start;
    logic        mult_done;
    logic [15:0] mult_product;
    logic        busy;
    logic        err_pulse;

    modport master (
        input  uart_rx_valid,
        input  uart_received_data,
        input  uart_tx_ready,
        output uart_tx_start,
        output uart_transmit_data,
        output mult_a,
        output mult_b,
        output mult_start,
        input  mult_done,
        input  mult_product,
        output busy,
        output err_pulse
    );

    modport slave (
        output uart_rx_valid,
        output uart_received_data,
        output uart_tx_ready,
        input  uart_tx_start,
        input  uart_transmit_data,
        input  mult_a,
        input  mult_b,
        input  mult_start,
        output mult_done,
        output mult_product,
        input  busy,
        input  err_pulse
    );
endinterface

// File: rtl/uart_mult_ctrl.sv
// uart_mult_ctrl: byte-protocol front end for an external 8x8 multiplier.
//   Frame 02 a b : multiply a*b, return product high byte then low byte.
//   Frame 0A     : return the last stored product (00 00 after reset).
//   Other opcode : return ERR_BYTE and pulse err_pulse.
// Ports:
//   clk_int    - single clock, rising edge
//   ctrl_reset - synchronous active-high reset; forces every output low
//   bus        - uart_mult_ctrl_if.master (rx strobe/data, tx handshake,
//                multiplier handshake, busy, err_pulse)
module uart_mult_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
    input  logic             clk_int,
    input  logic             ctrl_reset,
    uart_mult_ctrl_if.master bus
);
    localparam logic [7:0]  OP_MUL      = 8'h02;
    localparam logic [7:0]  OP_READ     = 8'h0A;
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        IDLE,
        GET_A,
        GET_B,
        MUL_START,
        MUL_WAIT,
        TX_HI,
        TX_HI_WAIT,
        TX_LO,
        TX_LO_WAIT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] evt_cnt;
    logic [15:0] last_prod;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic        lo_is_err;
    logic        tx_req;
    logic        err_q;
    logic        err_nx;
    logic        rx_accept;
    logic        timeout;
    logic        tx_phase;

    assign timeout  = (evt_cnt >= TIMEOUT_CNT);
    assign tx_phase = (state == TX_HI) || (state == TX_LO);

    // State register
    always_ff @(posedge clk_int) begin
        if (ctrl_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; rx bytes not consumed by the current state are overruns
    always_comb begin
        state_nx  = state;
        rx_accept = 1'b0;
        err_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.uart_rx_valid) begin
                    rx_accept = 1'b1;
                    if (bus.uart_received_data == OP_MUL) begin
                        state_nx = GET_A;
                    end else if (bus.uart_received_data == OP_READ) begin
                        state_nx = TX_HI;
                    end else begin
                        state_nx = TX_LO;
                        err_nx   = 1'b1;
                    end
                end
            end
            GET_A: begin
                if (bus.uart_rx_valid) begin
                    rx_accept = 1'b1;
                    state_nx  = GET_B;
                end else if (timeout) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            GET_B: begin
                if (bus.uart_rx_valid) begin
                    rx_accept = 1'b1;
                    state_nx  = MUL_START;
                end else if (timeout) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            MUL_START: state_nx = MUL_WAIT;
            MUL_WAIT: begin
                if (bus.mult_done) begin
                    state_nx = TX_HI;
                end else if (timeout) begin
                    state_nx = IDLE;
                    err_nx   = 1'b1;
                end
            end
            // Leave once the transmitter has taken the byte (ready dropped
            // while our request was up).
            TX_HI:      if (tx_req && !bus.uart_tx_ready) state_nx = TX_HI_WAIT;
            TX_HI_WAIT: if (bus.uart_tx_ready)            state_nx = TX_LO;
            TX_LO:      if (tx_req && !bus.uart_tx_ready) state_nx = TX_LO_WAIT;
            TX_LO_WAIT: if (bus.uart_tx_ready)            state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
        if (bus.uart_rx_valid && !rx_accept) begin
            err_nx = 1'b1;
        end
    end

    // Datapath and auxiliary control registers
    always_ff @(posedge clk_int) begin
        if (ctrl_reset) begin
            evt_cnt   <= '0;
            last_prod <= '0;
            a_q       <= '0;
            b_q       <= '0;
            lo_is_err <= 1'b0;
            tx_req    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= err_nx;

            // Saturating so a long IDLE never wraps into a false timeout.
            if ((state_nx != state) || rx_accept) begin
                evt_cnt <= '0;
            end else if (evt_cnt != 16'hFFFF) begin
                evt_cnt <= evt_cnt + 16'd1;
            end

            if ((state == GET_A) && rx_accept) begin
                a_q <= bus.uart_received_data;
            end
            if ((state == GET_B) && rx_accept) begin
                b_q <= bus.uart_received_data;
            end
            if ((state == MUL_WAIT) && bus.mult_done) begin
                last_prod <= bus.mult_product;
            end
            if ((state == IDLE) && rx_accept) begin
                lo_is_err <= (bus.uart_received_data != OP_MUL) &&
                             (bus.uart_received_data != OP_READ);
            end

            // Request rises only when ready is seen high and holds until
            // the state moves on after ready drops.
            tx_req <= tx_phase && (state_nx == state) && (tx_req || bus.uart_tx_ready);
        end
    end

    // Output logic; everything forced low while reset is held
    always_comb begin
        bus.busy               = (state != IDLE);
        bus.mult_start         = (state == MUL_START);
        bus.uart_tx_start      = tx_req;
        bus.mult_a             = a_q;
        bus.mult_b             = b_q;
        bus.err_pulse          = err_q;
        bus.uart_transmit_data = 8'h00;
        case (state)
            TX_HI, TX_HI_WAIT: bus.uart_transmit_data = last_prod[15:8];
            TX_LO, TX_LO_WAIT: bus.uart_transmit_data = lo_is_err ? ERR_BYTE : last_prod[7:0];
            default:           bus.uart_transmit_data = 8'h00;
        endcase
        if (ctrl_reset) begin
            bus.busy               = 1'b0;
            bus.mult_start         = 1'b0;
            bus.uart_tx_start      = 1'b0;
            bus.mult_a             = 8'h00;
            bus.mult_b             = 8'h00;
            bus.err_pulse          = 1'b0;
            bus.uart_transmit_data = 8'h00;
        end
    end
endmodule

// File: tb/tb_uart_mult_ctrl.sv
// Self-checking bench for uart_mult_ctrl: randomized frames against a
// frame-level reference model (expected tx byte queue, expected multiplier
// operations, expected error-pulse count).
`timescale 1ns/1ps
module tb_uart_mult_ctrl;
    localparam int unsigned TO   = 300;
    localparam logic [7:0]  ERRB = 8'hEE;

    logic clk_int = 1'b0;
    logic ctrl_reset;

    uart_mult_ctrl_if bus();

    uart_mult_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .ERR_BYTE      (ERRB)
    ) dut (
        .clk_int   (clk_int),
        .ctrl_reset(ctrl_reset),
        .bus       (bus)
    );

    always #5 clk_int = ~clk_int;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  obs_tx[$];
    logic [7:0]  exp_tx[$];
    logic [15:0] obs_mul[$];
    logic [15:0] exp_mul[$];
    int          err_seen = 0;
    int          err_exp  = 0;
    logic [15:0] last_prod_m = 16'h0000;
    logic [7:0]  ma = 8'h00;
    logic [7:0]  mb = 8'h00;
    bit          ma_known = 1'b0;
    bit          spurious_req = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: takes a byte when idle and start is seen, then is busy a while.
    initial begin
        int left;
        left = 0;
        bus.uart_tx_ready = 1'b1;
        forever begin
            @(negedge clk_int);
            if (bus.uart_tx_ready && bus.uart_tx_start) begin
                obs_tx.push_back(bus.uart_transmit_data);
                bus.uart_tx_ready = 1'b0;
                left = $urandom_range(4, 10);
            end else begin
                if (bus.uart_tx_start) begin
                    if (obs_tx.size() > 0) check_val("tx_data_stable", 32'(bus.uart_transmit_data), 32'(obs_tx[$]));
                    else                   check_val("tx_start_while_busy", 32'(bus.uart_tx_start), 0);
                end
                if (!bus.uart_tx_ready) begin
                    left--;
                    if (left == 0) bus.uart_tx_ready = 1'b1;
                end
            end
        end
    end

    // Multiplier model: records operands on start, answers after a random latency.
    initial begin
        int lat;
        int run;
        lat = 0;
        run = 0;
        bus.mult_done    = 1'b0;
        bus.mult_product = 16'h0000;
        forever begin
            @(negedge clk_int);
            bus.mult_done = 1'b0;
            if (bus.mult_start) begin
                run++;
            end else begin
                if (run > 0) check_val("mult_start_len", run, 1);
                run = 0;
            end
            if (lat > 0) begin
                lat--;
                if (lat == 0) bus.mult_done = 1'b1;
            end else if (spurious_req) begin
                spurious_req     = 1'b0;
                bus.mult_product = 16'hDEAD;
                bus.mult_done    = 1'b1;
            end
            if (bus.mult_start && run == 1) begin
                obs_mul.push_back({bus.mult_a, bus.mult_b});
                bus.mult_product = 16'(bus.mult_a) * 16'(bus.mult_b);
                lat = $urandom_range(1, 6);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_int);
            if (bus.err_pulse) err_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_int);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_int);
        bus.uart_rx_valid      = 1'b1;
        bus.uart_received_data = b;
        @(negedge clk_int);
        bus.uart_rx_valid      = 1'b0;
        bus.uart_received_data = 8'($urandom);
        tick($urandom_range(0, 3));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 3000) begin
            @(negedge clk_int);
            n++;
        end
        check_val({tag, "_idle"}, 32'(bus.busy), 0);
        tick(2);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k;
        k = 0;
        while (obs_tx.size() < n && k < 300) begin
            @(negedge clk_int);
            k++;
        end
        if (obs_tx.size() < n) check_val({tag, "_tx_wait"}, obs_tx.size(), n);
    endtask

    task automatic drain_compare(input string tag);
        logic [7:0]  o8, e8;
        logic [15:0] o16, e16;
        check_val({tag, "_ntx"}, obs_tx.size(), exp_tx.size());
        while (obs_tx.size() > 0 && exp_tx.size() > 0) begin
            o8 = obs_tx.pop_front();
            e8 = exp_tx.pop_front();
            check_val({tag, "_tx"}, 32'(o8), 32'(e8));
        end
        obs_tx.delete();
        exp_tx.delete();
        check_val({tag, "_nmul"}, obs_mul.size(), exp_mul.size());
        while (obs_mul.size() > 0 && exp_mul.size() > 0) begin
            o16 = obs_mul.pop_front();
            e16 = exp_mul.pop_front();
            check_val({tag, "_mul_ab"}, 32'(o16), 32'(e16));
        end
        obs_mul.delete();
        exp_mul.delete();
        check_val({tag, "_err"}, err_seen, err_exp);
        if (ma_known) check_val({tag, "_ab_hold"}, 32'({bus.mult_a, bus.mult_b}), 32'({ma, mb}));
    endtask

    // Byte injected while the controller waits for the transmitter after the high byte.
    task automatic inject_overrun(input string tag);
        wait_tx(1, tag);
        send_byte(8'($urandom));
        err_exp++;
    endtask

    task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input bit inject, input string tag);
        send_byte(8'h02);
        send_byte(a);
        send_byte(b);
        exp_mul.push_back({a, b});
        last_prod_m = 16'(a) * 16'(b);
        exp_tx.push_back(last_prod_m[15:8]);
        exp_tx.push_back(last_prod_m[7:0]);
        ma = a;
        mb = b;
        ma_known = 1'b1;
        if (inject) inject_overrun(tag);
        wait_idle(tag);
        drain_compare(tag);
    endtask

    task automatic do_read(input bit inject, input string tag);
        send_byte(8'h0A);
        exp_tx.push_back(last_prod_m[15:8]);
        exp_tx.push_back(last_prod_m[7:0]);
        if (inject) inject_overrun(tag);
        wait_idle(tag);
        drain_compare(tag);
    endtask

    task automatic do_bad(input logic [7:0] op, input string tag);
        send_byte(op);
        err_exp++;
        exp_tx.push_back(ERRB);
        wait_idle(tag);
        drain_compare(tag);
    endtask

    // Frame abandoned after the opcode (n=0) or after operand A (n=1).
    task automatic do_partial(input int n, input string tag);
        logic [7:0] a;
        a = 8'($urandom);
        send_byte(8'h02);
        if (n > 0) begin
            send_byte(a);
            if (ma_known) ma = a;
        end
        err_exp++;
        wait_idle(tag);
        drain_compare(tag);
    endtask

    initial begin
        logic [7:0] op;
        logic [7:0] ra;
        logic [7:0] rb;
        int         kind;
        bus.uart_rx_valid      = 1'b0;
        bus.uart_received_data = 8'h00;
        ctrl_reset = 1'b1;
        tick(3);
        check_val("reset_outputs", 32'({bus.uart_tx_start, bus.uart_transmit_data, bus.mult_a,
                  bus.mult_b, bus.mult_start, bus.busy, bus.err_pulse}), 0);
        ctrl_reset = 1'b0;
        tick(2);
        check_val("post_reset_busy", 32'(bus.busy), 0);

        do_read(1'b0, "read_before_mul");
        do_mul(8'h07, 8'h09, 1'b0, "mul_07_09");
        do_read(1'b0, "read_after_mul");
        do_bad(8'h55, "bad_55");
        do_partial(1, "timeout_after_a");
        do_mul(8'hFF, 8'hFF, 1'b0, "mul_ff_ff");
        do_mul(8'($urandom), 8'($urandom), 1'b1, "overrun_tx_hi_wait");

        spurious_req = 1'b1;
        tick(4);
        do_read(1'b0, "read_after_stray_done");

        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 5);
            ra = 8'($urandom);
            rb = 8'($urandom);
            case (kind)
                0: do_mul(ra, rb, 1'b0, "rnd_mul");
                1: do_mul(ra, rb, 1'b1, "rnd_mul_ovr");
                2: do_read($urandom_range(0, 1) == 1, "rnd_read");
                3: begin
                    op = 8'($urandom);
                    while (op == 8'h02 || op == 8'h0A) op = 8'($urandom);
                    do_bad(op, "rnd_bad");
                end
                4: do_partial($urandom_range(0, 1), "rnd_timeout");
                default: do_mul(8'hFF, rb, 1'b0, "rnd_mul_edge");
            endcase
        end

        // Reset in the middle of a response: only the high byte goes out.
        ra = 8'($urandom);
        rb = 8'($urandom);
        send_byte(8'h02);
        send_byte(ra);
        send_byte(rb);
        exp_mul.push_back({ra, rb});
        last_prod_m = 16'(ra) * 16'(rb);
        exp_tx.push_back(last_prod_m[15:8]);
        wait_tx(1, "reset_mid_tx");
        @(negedge clk_int);
        ctrl_reset = 1'b1;
        @(negedge clk_int);
        check_val("reset_mid_outputs", 32'({bus.uart_tx_start, bus.uart_transmit_data, bus.mult_a,
                  bus.mult_b, bus.mult_start, bus.busy, bus.err_pulse}), 0);
        ctrl_reset = 1'b0;
        last_prod_m = 16'h0000;
        ma_known = 1'b0;
        @(negedge clk_int);
        check_val("reset_mid_busy", 32'(bus.busy), 0);
        tick(2);
        drain_compare("reset_mid_tx");
        do_read(1'b0, "read_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_mult_ctrl.md
UART_MULT_CTRL -- requirements
Module: uart_mult_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000, giving the maximum clk_int cycles allowed between frame bytes and for the multiplier wait.
REQ-002 SHALL have parameter ERR_BYTE, default 8'hEE, the byte returned for an unknown opcode.
REQ-003 SHALL have port clk_int  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port ctrl_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port uart_rx_valid  input  1  one-cycle strobe: uart_received_data holds a new byte.
REQ-006 SHALL have port uart_received_data  input  8  received byte.
REQ-007 SHALL have port uart_tx_ready  input  1  high when the transmitter is idle; low while sending.
REQ-008 SHALL have port uart_tx_start  output  1  transmit request.
REQ-009 SHALL have port uart_transmit_data  output  8  byte to transmit.
REQ-010 SHALL have port mult_a  output  8  multiplier operand A.
REQ-011 SHALL have port mult_b  output  8  multiplier operand B.
REQ-012 SHALL have port mult_start  output  1  one-cycle multiplier start pulse.
REQ-013 SHALL have port mult_done  input  1  one-cycle strobe: mult_product is valid.
REQ-014 SHALL have port mult_product  input  16  unsigned product.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port err_pulse  output  1  one-cycle pulse on timeout, unknown opcode or overrun.

Function
REQ-017 SHALL implement states IDLE, GET_A, GET_B, MUL_START, MUL_WAIT, TX_HI, TX_HI_WAIT, TX_LO, TX_LO_WAIT.
REQ-018 IDLE, rx byte 8'h02 -> GET_A; byte 8'h0A -> TX_HI with the stored last product; any other byte -> TX_LO with ERR_BYTE, plus err_pulse.
REQ-019 GET_A: on rx, latch mult_a -> GET_B. GET_B: on rx, latch mult_b -> MUL_START.
REQ-020 MUL_START: mult_start high for exactly one cycle -> MUL_WAIT.
REQ-021 MUL_WAIT: on mult_done, latch mult_product into the last-product register -> TX_HI.
REQ-022 TX_HI: drive uart_transmit_data = product[15:8] and hold uart_tx_start high until uart_tx_ready is sampled low; then deassert uart_tx_start -> TX_HI_WAIT.
REQ-023 TX_HI_WAIT: wait for uart_tx_ready high -> TX_LO.
REQ-024 TX_LO and TX_LO_WAIT: same as REQ-022 and REQ-023 with product[7:0] (or ERR_BYTE); on completion -> IDLE.
REQ-025 TX_HI and TX_LO SHALL NOT assert uart_tx_start while uart_tx_ready is low on state entry; uart_tx_start stays low until ready is high.
REQ-026 uart_transmit_data SHALL be stable for the whole time uart_tx_start is high.
REQ-027 A 16-bit inter-event counter SHALL reset on every state change and on every accepted rx byte.
REQ-028 In GET_A, GET_B or MUL_WAIT, counter reaching TIMEOUT_CYCLES -> IDLE with err_pulse; no bytes transmitted.
REQ-029 rx_valid in MUL_START, MUL_WAIT or any TX state SHALL be dropped with err_pulse; state unaffected.
REQ-030 Opcode 8'h0A before any multiply SHALL return 8'h00, 8'h00.
REQ-031 mult_a and mult_b SHALL hold their values until the next 8'h02 frame overwrites them.
REQ-032 mult_done outside MUL_WAIT SHALL be ignored.

Reset
REQ-033 ctrl_reset high at a clock edge SHALL force IDLE from any state, including mid-frame and mid-transmit.
REQ-034 ctrl_reset SHALL clear the counter and the last-product register.
REQ-035 While ctrl_reset is high, all outputs SHALL be 0 (uart_tx_start, uart_transmit_data, mult_a, mult_b, mult_start, busy, err_pulse).

Verification
REQ-036 Rx 02,07,09 with the multiplier model returning 16'h003F -> one mult_start pulse with mult_a=07 and mult_b=09; tx bytes 00 then 3F; busy low afterwards.
REQ-037 After REQ-036, rx 0A -> tx 00, 3F with no mult_start.
REQ-038 Rx 55 -> err_pulse, then tx EE, then IDLE.
REQ-039 Rx 02,07 followed by silence longer than TIMEOUT_CYCLES -> err_pulse, return to IDLE, no tx; a following 02,FF,FF frame returns FE, 01.
REQ-040 Rx byte injected during TX_HI_WAIT -> err_pulse; transmitted bytes unchanged.
REQ-041 ctrl_reset asserted during TX_HI_WAIT -> next cycle IDLE with all outputs 0; a following 0A returns 00, 00.
